stacker_game_fsm: RTL and testbench



---
 rtl/stacker_pkg.sv | 35 +++
 rtl/stacker_row_mask.sv | 43 ++++
 rtl/stacker_game_fsm.sv | 172 +++++++++++++++++
 tb/tb_stacker_game_fsm.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stacker_pkg.sv
// -----------------------------------------------------------------------------
// stacker_pkg
// Shared definitions for the 8x8 block-stacking game engine.
//   - state_e     : state codes shown on the seven-segment display
//   - ROWS/COLS   : display array geometry
//   - ROW_W       : width of one row pattern
//   - count_ones  : population count of a row pattern
// -----------------------------------------------------------------------------
package stacker_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int ROW_W = 8;

    // Codes are displayed directly on the SSD, so the values are fixed.
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MOVE  = 3'd2,
        ST_CHECK = 3'd3,
        ST_WIN   = 3'd4,
        ST_LOSE  = 3'd5
    } state_e;

    // Number of lit columns in a row pattern (0..8).
    function automatic logic [3:0] count_ones(input logic [ROW_W-1:0] vec);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < ROW_W; i++) begin
            cnt = cnt + {3'b000, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/stacker_row_mask.sv
// -----------------------------------------------------------------------------
// stacker_row_mask
// Combinational row helper shared by the load, move and lock steps.
// Ports:
//   pos           in  3  left-edge column of the block
//   width         in  4  block width in columns
//   prev          in  8  locked pattern of the row below
//   pattern       out 8  block pattern; bit (7-c) lit iff pos <= c <= pos+width-1
//   overlap       out 8  pattern & prev (what survives a lock)
//   overlap_width out 4  number of lit columns in overlap
// -----------------------------------------------------------------------------
module stacker_row_mask
    import stacker_pkg::*;
(
    input  logic [2:0] pos,
    input  logic [3:0] width,
    input  logic [7:0] prev,
    output logic [7:0] pattern,
    output logic [7:0] overlap,
    output logic [3:0] overlap_width
);

    // One past the right-most lit column; up to 7+8=15, so 4 bits suffice.
    logic [3:0] right_s;

    assign right_s = {1'b0, pos} + width;

    // Light every column inside the half-open range [pos, pos+width).
    always_comb begin
        pattern = 8'h00;
        for (int c = 0; c < COLS; c++) begin
            if ((4'(c) >= {1'b0, pos}) && (4'(c) < right_s)) begin
                pattern[7-c] = 1'b1;
            end else begin
                pattern[7-c] = 1'b0;
            end
        end
    end

    assign overlap       = pattern & prev;
    assign overlap_width = count_ones(overlap);

endmodule

// File: rtl/stacker_game_fsm.sv
// -----------------------------------------------------------------------------
// stacker_game_fsm
// Game engine for the 8x8 block-stacking display. A block slides left/right
// on the current row; a button press locks it, trims it to its overlap with
// the row below and climbs one row. Every change of the visible row is sent
// to the display array as a one-cycle write.
// Parameters:
//   INIT_WIDTH  block width on row 0 (1..7)
// Ports:
//   clk          in  1  system clock
//   reset        in  1  synchronous, active-high
//   btn          in  1  single-cycle debounced button pulse
//   update_clk   in  1  single-cycle move tick
//   val          out 8  row pattern; bit (7-col) lit means column col filled
//   row_index    out 3  row being written; 0 = bottom
//   write_strobe out 1  one-cycle write enable for val/row_index
//   clr_array    out 1  one-cycle clear of the display array
//   state        out 3  state code of the step that produced this cycle's outputs
// -----------------------------------------------------------------------------
module stacker_game_fsm
    import stacker_pkg::*;
#(
    parameter int INIT_WIDTH = 3
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       update_clk,
    output logic [7:0] val,
    output logic [2:0] row_index,
    output logic       write_strobe,
    output logic       clr_array,
    output logic [2:0] state
);

    state_e     st_r;
    logic [2:0] row_r;
    logic [2:0] pos_r;
    logic [3:0] width_r;
    logic       dir_r;      // 0 = moving right (increasing column)
    logic [7:0] prev_r;

    logic [2:0] next_pos_s;
    logic       next_dir_s;
    logic       move_tick_s;
    logic [2:0] mask_pos_s;
    logic [7:0] pattern_s;
    logic [7:0] overlap_s;
    logic [3:0] overlap_width_s;

    // A button in the same cycle as a tick takes priority, so the tick is lost.
    assign move_tick_s = (st_r == ST_MOVE) && update_clk && !btn;

    // Next position/direction for one tick; the block reverses and steps in the
    // same tick, so it never dwells on an edge.
    always_comb begin
        next_pos_s = pos_r;
        next_dir_s = dir_r;
        if (!dir_r) begin
            if (({1'b0, pos_r} + width_r) == 4'd8) begin
                next_dir_s = 1'b1;
                next_pos_s = pos_r - 3'd1;
            end else begin
                next_pos_s = pos_r + 3'd1;
            end
        end else begin
            if (pos_r == 3'd0) begin
                next_dir_s = 1'b0;
                next_pos_s = 3'd1;
            end else begin
                next_pos_s = pos_r - 3'd1;
            end
        end
    end

    // On a tick the mask is evaluated at the new position so the write issued
    // by that tick already shows where the block moved to.
    assign mask_pos_s = move_tick_s ? next_pos_s : pos_r;

    stacker_row_mask u_row_mask (
        .pos           (mask_pos_s),
        .width         (width_r),
        .prev          (prev_r),
        .pattern       (pattern_s),
        .overlap       (overlap_s),
        .overlap_width (overlap_width_s)
    );

    // Game state machine with registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_r         <= ST_INIT;
            row_r        <= 3'd0;
            pos_r        <= 3'd0;
            width_r      <= 4'(INIT_WIDTH);
            dir_r        <= 1'b0;
            prev_r       <= 8'hFF;
            val          <= 8'h00;
            row_index    <= 3'd0;
            write_strobe <= 1'b0;
            clr_array    <= 1'b0;
            state        <= ST_INIT;
        end else begin
            write_strobe <= 1'b0;
            clr_array    <= 1'b0;
            state        <= st_r;
            case (st_r)
                ST_INIT: begin
                    clr_array <= 1'b1;
                    row_r     <= 3'd0;
                    pos_r     <= 3'd0;
                    width_r   <= 4'(INIT_WIDTH);
                    dir_r     <= 1'b0;
                    prev_r    <= 8'hFF;
                    st_r      <= ST_LOAD;
                end
                ST_LOAD: begin
                    write_strobe <= 1'b1;
                    val          <= pattern_s;
                    row_index    <= row_r;
                    st_r         <= ST_MOVE;
                end
                ST_MOVE: begin
                    if (btn) begin
                        st_r <= ST_CHECK;
                    end else if (update_clk) begin
                        pos_r        <= next_pos_s;
                        dir_r        <= next_dir_s;
                        write_strobe <= 1'b1;
                        val          <= pattern_s;
                        row_index    <= row_r;
                    end else begin
                        st_r <= ST_MOVE;
                    end
                end
                ST_CHECK: begin
                    if (overlap_s == 8'h00) begin
                        st_r <= ST_LOSE;
                    end else begin
                        // Overlap of two contiguous runs is contiguous, so
                        // its popcount is the new block width.
                        write_strobe <= 1'b1;
                        val          <= overlap_s;
                        row_index    <= row_r;
                        prev_r       <= overlap_s;
                        width_r      <= overlap_width_s;
                        if (row_r == 3'(ROWS - 1)) begin
                            st_r <= ST_WIN;
                        end else begin
                            row_r <= row_r + 3'd1;
                            pos_r <= 3'd0;
                            dir_r <= 1'b0;
                            st_r  <= ST_LOAD;
                        end
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (btn) begin
                        st_r <= ST_INIT;
                    end else begin
                        st_r <= st_r;
                    end
                end
                default: begin
                    st_r <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stacker_game_fsm.sv
// -----------------------------------------------------------------------------
// tb_stacker_game_fsm
// Scoreboard bench: the driver updates a game-level model and queues the
// display events (clear / row write) it expects; a monitor pops and compares
// every event the DUT presents.
// -----------------------------------------------------------------------------
module tb_stacker_game_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn;
    logic       update_clk;
    logic [7:0] val;
    logic [2:0] row_index;
    logic       write_strobe;
    logic       clr_array;
    logic [2:0] state;

    localparam int W0 = 3;

    stacker_game_fsm #(.INIT_WIDTH(W0)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .update_clk   (update_clk),
        .val          (val),
        .row_index    (row_index),
        .write_strobe (write_strobe),
        .clr_array    (clr_array),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_clr;
        logic [2:0] row;
        logic [7:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    // Game-level model: phase 0 = playing, 1 = won, 2 = lost.
    int         m_phase;
    int         m_row;
    int         m_pos;
    int         m_width;
    int         m_step;   // +1 moving right, -1 moving left
    logic [7:0] m_prev;

    function automatic logic [7:0] shape(int p, int w);
        logic [7:0] r;
        r = 8'h00;
        for (int c = 0; c < 8; c++) begin
            if (c >= p && c < p + w) r[7-c] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [2:0] exp_state();
        if (m_phase == 1) return 3'd4;
        if (m_phase == 2) return 3'd5;
        return 3'd2;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push_write(int r, logic [7:0] v);
        ev_t e;
        e.is_clr = 1'b0;
        e.row    = 3'(r);
        e.val    = v;
        exp_q.push_back(e);
    endtask

    task automatic new_game();
        ev_t e;
        e.is_clr = 1'b1;
        e.row    = 3'd0;
        e.val    = 8'h00;
        exp_q.push_back(e);
        m_phase = 0;
        m_row   = 0;
        m_pos   = 0;
        m_width = W0;
        m_step  = 1;
        m_prev  = 8'hFF;
        push_write(0, shape(0, W0));
    endtask

    // One clock with the given inputs; returns 2 time units after the edge.
    task automatic step(bit b, bit t);
        btn        = b;
        update_clk = t;
        @(posedge clk);
        #2;
        btn        = 1'b0;
        update_clk = 1'b0;
    endtask

    task automatic settle();
        repeat (3) step(1'b0, 1'b0);
        check("state_settled", state, exp_state());
    endtask

    task automatic do_tick();
        if (m_phase == 0) begin
            // Bounce: if the step would leave the board, reverse and step.
            if (m_pos + m_step < 0 || m_pos + m_step + m_width > 8) m_step = -m_step;
            m_pos = m_pos + m_step;
            push_write(m_row, shape(m_pos, m_width));
        end
        step(1'b0, 1'b1);
        check("state_tick", state, exp_state());
    endtask

    task automatic do_btn(bit with_tick);
        logic [7:0] ov;
        if (m_phase == 0) begin
            ov = shape(m_pos, m_width) & m_prev;
            if (ov == 8'h00) begin
                m_phase = 2;
            end else begin
                push_write(m_row, ov);
                m_prev  = ov;
                m_width = $countones(ov);
                if (m_row == 7) begin
                    m_phase = 1;
                end else begin
                    m_row  = m_row + 1;
                    m_pos  = 0;
                    m_step = 1;
                    push_write(m_row, shape(0, m_width));
                end
            end
        end else begin
            new_game();
        end
        step(1'b1, with_tick);
        settle();
    endtask

    // Monitor: every clear or write the DUT presents must match the queue head.
    always @(negedge clk) begin
        ev_t e;
        if (write_strobe || clr_array) begin
            check("strobe_clr_exclusive", 32'(write_strobe & clr_array), 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got strobe=%0b clr=%0b row=%0d val=%0h want none",
                         write_strobe, clr_array, row_index, val);
            end else begin
                e = exp_q.pop_front();
                check("event_kind_clr", 32'(clr_array), 32'(e.is_clr));
                if (!e.is_clr) begin
                    check("write_row", 32'(row_index), 32'(e.row));
                    check("write_val", 32'(val), 32'(e.val));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        btn        = 1'b0;
        update_clk = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_val", val, 8'h00);
        check("reset_row", row_index, 3'd0);
        check("reset_ws", write_strobe, 1'b0);
        check("reset_clr", clr_array, 1'b0);
        check("reset_state", state, 3'd0);

        // Release, then reset again during the first LOAD strobe.
        reset = 1'b0;
        new_game();
        step(1'b0, 1'b0);
        check("init_clr", clr_array, 1'b1);
        check("init_state", state, 3'd0);
        step(1'b0, 1'b0);
        check("load_ws", write_strobe, 1'b1);
        check("load_val", val, 8'hE0);
        check("load_state", state, 3'd1);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("midload_reset_ws", write_strobe, 1'b0);
        check("midload_reset_val", val, 8'h00);
        check("midload_reset_state", state, 3'd0);
        check("midload_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        new_game();
        settle();

        // Game 1: sweep right, bounce, return to column 0.
        for (int i = 1; i <= 10; i++) begin
            do_tick();
            if (i == 5)  check("tick5_val", val, 8'h07);
            if (i == 6)  check("tick6_val", val, 8'h0E);
            if (i == 10) check("tick10_val", val, 8'hE0);
        end
        do_btn(1'b0);                       // lock E0 on row 0
        do_tick();
        check("row1_tick_val", val, 8'h70);
        do_btn(1'b0);                       // lock 60 on row 1
        check("row2_load_val", val, 8'hC0);
        check("row2_load_row", row_index, 3'd2);
        repeat (3) do_tick();               // 18 over 60 -> miss
        do_btn(1'b0);
        check("lose_state", state, 3'd5);
        repeat (2) do_tick();               // ignored in LOSE
        do_btn(1'b0);                       // restart

        // Game 2: row 1 at 1C over E0 loses.
        do_btn(1'b0);
        repeat (3) do_tick();
        check("row1_1c_val", val, 8'h1C);
        do_btn(1'b0);
        check("lose2_state", state, 3'd5);
        do_btn(1'b0);                       // restart

        // Game 3: lock all eight rows at column 0.
        repeat (8) do_btn(1'b0);
        check("win_state", state, 3'd4);
        check("win_row", row_index, 3'd7);
        check("win_val", val, 8'hE0);
        do_tick();
        do_btn(1'b0);                       // restart

        // Game 4: bounce off the left edge, then btn and tick together.
        for (int i = 1; i <= 11; i++) do_tick();
        check("tick11_val", val, 8'h70);
        do_btn(1'b1);

        // Randomized play.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 60)      do_tick();
            else if (r < 78) do_btn(1'b0);
            else if (r < 83) do_btn(1'b1);
            else             step(1'b0, 1'b0);
        end

        repeat (3) step(1'b0, 1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
